sc_stream_ctrl: RTL and testbench

- Consumes the random words of one LFSR_*_added_zero generator in the stochastic Sobel datapath.
- Drives that generator's enable/restart and converts a binary pixel value into a unipolar stochastic bitstream (comparator SNG).
- Counts the ones returned by the downstream SC kernel over one full stream and hands back the binary result through valid/ready handshakes.
- One instance per stream lane; the LFSR period, including the added zero, is 2^WIDTH.

---
 rtl/sc_pkg.sv | 21 ++
 rtl/sc_stream_ctrl_ones_counter.sv | 54 +++++
 rtl/sc_stream_ctrl.sv | 128 ++++++++++++
 tb/tb_sc_stream_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic stream controller.
//   sc_ctrl_state_t : controller FSM state encoding
//   stream_len()    : number of stream cycles for a given word width
//   MAX_KERNEL_LAT  : deepest supported kernel pipeline
package sc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } sc_ctrl_state_t;

  localparam int MAX_KERNEL_LAT = 15;

  function automatic int unsigned stream_len(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/sc_stream_ctrl_ones_counter.sv
// sc_ones_counter: counts returned stochastic ones over the stream window.
// The window marker is delayed by KERNEL_LAT cycles so that it lines up with
// the kernel output.
//   clk, reset : clock, async active-low reset
//   clr        : clear the count (start of a new stream)
//   win        : stream window marker (sc_bit_valid)
//   sc_in      : stochastic bit returned by the kernel
//   count      : ones count, WIDTH+1 bits so a full stream of ones fits
//   busy       : window still active or still travelling through the delay
module sc_ones_counter #(
  parameter int WIDTH      = 8,
  parameter int KERNEL_LAT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             win,
  input  logic             sc_in,
  output logic [WIDTH:0]   count,
  output logic             busy
);

  logic cnt_en;

  if (KERNEL_LAT == 0) begin : g_nolat
    assign cnt_en = win;
    assign busy   = win;
  end else begin : g_lat
    logic [KERNEL_LAT-1:0] sr;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sr <= '0;
      end else begin
        sr[0] <= win;
        for (int i = 1; i < KERNEL_LAT; i++) sr[i] <= sr[i-1];
      end
    end

    assign cnt_en = sr[KERNEL_LAT-1];
    assign busy   = win | (|sr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (cnt_en && sc_in) begin
      count <= count + (WIDTH+1)'(1);
    end
  end

endmodule

// File: rtl/sc_stream_ctrl.sv
// sc_stream_ctrl: one stream lane of the stochastic Sobel datapath.
// Restarts and steps an added-zero LFSR, turns a binary value into a unipolar
// bitstream by comparison, counts the ones coming back from the kernel and
// returns the count through a valid/ready handshake.
//   clk, reset              : clock, async active-low reset
//   in_valid/in_ready/value : operand handshake (accepted only in IDLE)
//   lfsr_data               : current generator word
//   lfsr_enable/restart     : generator step / seed reload
//   sc_bit, sc_bit_valid    : registered stochastic bit and its window
//   sc_in                   : bit returned by the kernel (KERNEL_LAT later)
//   out_valid/out_ready     : result handshake
//   result                  : ones count, 0..2^WIDTH
// KERNEL_LAT must stay within 0..MAX_KERNEL_LAT.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// LOAD  | one cycle, generator reloads its seed
// RUN   | 2^WIDTH cycles of bit generation, generator stepping
// DRAIN | waiting for the delayed count window to close
// DONE  | result offered until out_ready
module sc_stream_ctrl
  import sc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int KERNEL_LAT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] lfsr_data,
  output logic             lfsr_enable,
  output logic             lfsr_restart,
  output logic             sc_bit,
  output logic             sc_bit_valid,
  input  logic             sc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result
);

  sc_ctrl_state_t   state;
  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] cyc;
  logic [WIDTH:0]   count;
  logic             busy;
  logic             clr;

  // Count clears on the accepting edge, so DONE of the previous stream
  // keeps its result visible until a new operand is taken.
  assign clr = (state == IDLE) && in_valid;

  sc_ones_counter #(
    .WIDTH      (WIDTH),
    .KERNEL_LAT (KERNEL_LAT)
  ) u_ones_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .win   (sc_bit_valid),
    .sc_in (sc_in),
    .count (count),
    .busy  (busy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      lfsr_enable  <= 1'b0;
      lfsr_restart <= 1'b0;
      sc_bit       <= 1'b0;
      sc_bit_valid <= 1'b0;
      out_valid    <= 1'b0;
      result       <= '0;
      value_q      <= '0;
      cyc          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            value_q      <= value;
            in_ready     <= 1'b0;
            lfsr_restart <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          lfsr_restart <= 1'b0;
          lfsr_enable  <= 1'b1;
          cyc          <= '0;
          state        <= RUN;
        end
        RUN: begin
          sc_bit       <= (value_q > lfsr_data);
          sc_bit_valid <= 1'b1;
          cyc          <= cyc + WIDTH'(1);
          // All-ones cyc is the last of the 2^WIDTH stream cycles.
          if (&cyc) begin
            lfsr_enable <= 1'b0;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          sc_bit       <= 1'b0;
          sc_bit_valid <= 1'b0;
          // busy covers sc_bit_valid itself, so the first DRAIN edge never
          // finishes: the last stream bit is still being counted.
          if (!busy) begin
            result    <= count;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_stream_ctrl.sv
// Bench for sc_stream_ctrl: three lanes (W8/L0 loopback, W8/L3 loopback
// through a 3-stage delay, W4 with a driven sc_in), each fed by a stepping
// permutation source that visits every word once per stream like an
// added-zero LFSR.
module tb_sc_stream_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // lane a: WIDTH=8, KERNEL_LAT=0
  logic       a_in_valid = 0, a_in_ready, a_lfsr_enable, a_lfsr_restart;
  logic       a_sc_bit, a_sc_bit_valid, a_out_valid, a_out_ready = 0;
  logic [7:0] a_value = 0, a_lfsr;
  logic [8:0] a_result;

  // lane b: WIDTH=8, KERNEL_LAT=3
  logic       b_in_valid = 0, b_in_ready, b_lfsr_enable, b_lfsr_restart;
  logic       b_sc_bit, b_sc_bit_valid, b_out_valid, b_out_ready = 0;
  logic [7:0] b_value = 0, b_lfsr;
  logic [8:0] b_result;
  logic [2:0] b_dly = 0;

  // lane c: WIDTH=4, KERNEL_LAT=0
  logic       c_in_valid = 0, c_in_ready, c_lfsr_enable, c_lfsr_restart;
  logic       c_sc_bit, c_sc_bit_valid, c_out_valid, c_out_ready = 0;
  logic       c_sc_in = 0;
  logic [3:0] c_value = 0, c_lfsr;
  logic [4:0] c_result;

  sc_stream_ctrl #(.WIDTH(8), .KERNEL_LAT(0)) u_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .value(a_value), .lfsr_data(a_lfsr), .lfsr_enable(a_lfsr_enable),
    .lfsr_restart(a_lfsr_restart), .sc_bit(a_sc_bit), .sc_bit_valid(a_sc_bit_valid),
    .sc_in(a_sc_bit), .out_valid(a_out_valid), .out_ready(a_out_ready), .result(a_result));

  sc_stream_ctrl #(.WIDTH(8), .KERNEL_LAT(3)) u_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .value(b_value), .lfsr_data(b_lfsr), .lfsr_enable(b_lfsr_enable),
    .lfsr_restart(b_lfsr_restart), .sc_bit(b_sc_bit), .sc_bit_valid(b_sc_bit_valid),
    .sc_in(b_dly[2]), .out_valid(b_out_valid), .out_ready(b_out_ready), .result(b_result));

  sc_stream_ctrl #(.WIDTH(4), .KERNEL_LAT(0)) u_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .value(c_value), .lfsr_data(c_lfsr), .lfsr_enable(c_lfsr_enable),
    .lfsr_restart(c_lfsr_restart), .sc_bit(c_sc_bit), .sc_bit_valid(c_sc_bit_valid),
    .sc_in(c_sc_in), .out_valid(c_out_valid), .out_ready(c_out_ready), .result(c_result));

  // Word sources: reload seed on restart, odd step when enabled.
  always @(posedge clk or negedge reset)
    if (!reset) a_lfsr <= 8'hA5;
    else if (a_lfsr_restart) a_lfsr <= 8'hA5;
    else if (a_lfsr_enable) a_lfsr <= a_lfsr + 8'd83;
  always @(posedge clk or negedge reset)
    if (!reset) b_lfsr <= 8'h3C;
    else if (b_lfsr_restart) b_lfsr <= 8'h3C;
    else if (b_lfsr_enable) b_lfsr <= b_lfsr + 8'd29;
  always @(posedge clk or negedge reset)
    if (!reset) c_lfsr <= 4'h9;
    else if (c_lfsr_restart) c_lfsr <= 4'h9;
    else if (c_lfsr_enable) c_lfsr <= c_lfsr + 4'd5;

  // Kernel stand-in for lane b: three pipeline stages.
  always @(posedge clk) b_dly <= {b_dly[1:0], b_sc_bit};

  // Cumulative cycle counts of enable / restart / sc_bit_valid per lane.
  int en_cnt[3], rs_cnt[3], vl_cnt[3];
  initial for (int i = 0; i < 3; i++) begin en_cnt[i] = 0; rs_cnt[i] = 0; vl_cnt[i] = 0; end
  always @(posedge clk) begin
    if (a_lfsr_enable) en_cnt[0]++;
    if (b_lfsr_enable) en_cnt[1]++;
    if (c_lfsr_enable) en_cnt[2]++;
    if (a_lfsr_restart) rs_cnt[0]++;
    if (b_lfsr_restart) rs_cnt[1]++;
    if (c_lfsr_restart) rs_cnt[2]++;
    if (a_sc_bit_valid) vl_cnt[0]++;
    if (b_sc_bit_valid) vl_cnt[1]++;
    if (c_sc_bit_valid) vl_cnt[2]++;
  end

  int checks = 0;
  int passed = 0;
  int sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [31:0] get_in_ready(input int w);
    case (w) 0: return {31'd0, a_in_ready}; 1: return {31'd0, b_in_ready}; default: return {31'd0, c_in_ready}; endcase
  endfunction
  function automatic logic [31:0] get_out_valid(input int w);
    case (w) 0: return {31'd0, a_out_valid}; 1: return {31'd0, b_out_valid}; default: return {31'd0, c_out_valid}; endcase
  endfunction
  function automatic logic [31:0] get_result(input int w);
    case (w) 0: return {23'd0, a_result}; 1: return {23'd0, b_result}; default: return {27'd0, c_result}; endcase
  endfunction

  task automatic set_in(input int w, input logic v, input int val);
    case (w)
      0: begin a_in_valid = v; a_value = val[7:0]; end
      1: begin b_in_valid = v; b_value = val[7:0]; end
      default: begin c_in_valid = v; c_value = val[3:0]; end
    endcase
  endtask

  task automatic set_out_ready(input int w, input logic v);
    case (w) 0: a_out_ready = v; 1: b_out_ready = v; default: c_out_ready = v; endcase
  endtask

  // One full stream on lane w. hold: cycles out_ready stays low in DONE.
  // poke: stray in_valid pulses during RUN and DONE that must be ignored.
  task automatic run_stream(input int w, input int val, input int exp_res,
                            input int exp_lat, input int hold, input bit poke);
    int n, e0, r0, v0, len, held, exp;
    bit got, stable;
    string nm;
    nm  = $sformatf("lane%0d_v%0d", w, val);
    len = (w == 2) ? 16 : 256;
    @(negedge clk);
    chk({nm, "_in_ready_idle"}, get_in_ready(w), 1);
    e0 = en_cnt[w]; r0 = rs_cnt[w]; v0 = vl_cnt[w];
    set_in(w, 1'b1, val);
    sb.push_back(exp_res);
    @(posedge clk);
    #1 set_in(w, 1'b0, ~val);   // operand changes after accept must not matter
    n = 0; got = 0;
    while (n < 600 && !got) begin
      @(posedge clk); n++;
      #1;
      if (poke) set_in(w, (n == 50), 5);
      if (get_out_valid(w) == 1) got = 1;
    end
    chk({nm, "_out_valid_seen"}, {31'd0, got}, 1);
    chk({nm, "_latency"}, n, exp_lat);
    exp = sb.pop_front();
    chk({nm, "_result"}, get_result(w), exp);
    chk({nm, "_in_ready_done"}, get_in_ready(w), 0);
    chk({nm, "_enable_cycles"}, en_cnt[w] - e0, len);
    chk({nm, "_restart_cycles"}, rs_cnt[w] - r0, 1);
    chk({nm, "_valid_cycles"}, vl_cnt[w] - v0, len);
    if (hold > 0) begin
      held = get_result(w);
      stable = 1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (poke) set_in(w, (i == 5), 7);
        if (get_out_valid(w) != 1 || get_result(w) != held || get_in_ready(w) != 0) stable = 0;
      end
      chk({nm, "_hold_stable"}, {31'd0, stable}, 1);
    end
    @(negedge clk);
    set_out_ready(w, 1'b1);
    @(posedge clk);
    #1 set_out_ready(w, 1'b0);
    chk({nm, "_out_valid_cleared"}, get_out_valid(w), 0);
    chk({nm, "_in_ready_back"}, get_in_ready(w), 1);
    if (poke) begin
      r0 = rs_cnt[w];
      repeat (10) @(posedge clk);
      #1;
      chk({nm, "_no_second_stream"}, rs_cnt[w] - r0, 0);
      chk({nm, "_still_idle"}, get_in_ready(w), 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, a_in_ready}, 1);
    chk("rst_out_valid", {31'd0, a_out_valid}, 0);
    chk("rst_result", {23'd0, a_result}, 0);
    chk("rst_enable", {31'd0, a_lfsr_enable}, 0);
    chk("rst_restart", {31'd0, a_lfsr_restart}, 0);
    chk("rst_sc_bit_valid", {31'd0, a_sc_bit_valid}, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    run_stream(0, 0,   0,   259, 0, 0);
    run_stream(0, 1,   1,   259, 0, 0);
    run_stream(0, 128, 128, 259, 0, 0);
    run_stream(0, 255, 255, 259, 0, 0);

    c_sc_in = 1'b1;
    run_stream(2, 3, 16, 19, 0, 0);
    c_sc_in = 1'b0;
    run_stream(2, 12, 0, 19, 0, 0);

    run_stream(1, 77, 77, 262, 0, 0);

    run_stream(0, 90, 90, 259, 20, 1);

    // Abort mid-RUN at cyc=100, then a fresh stream must complete normally.
    @(negedge clk);
    set_in(0, 1'b1, 123);
    @(posedge clk);
    #1 set_in(0, 1'b0, 0);
    repeat (101) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, a_in_ready}, 1);
    chk("abort_enable", {31'd0, a_lfsr_enable}, 0);
    chk("abort_restart", {31'd0, a_lfsr_restart}, 0);
    chk("abort_sc_bit", {31'd0, a_sc_bit}, 0);
    chk("abort_sc_bit_valid", {31'd0, a_sc_bit_valid}, 0);
    chk("abort_out_valid", {31'd0, a_out_valid}, 0);
    chk("abort_result", {23'd0, a_result}, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    run_stream(0, 200, 200, 259, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
